// File: rtl/amem_pkg.sv
// Shared types, default geometry and helpers for the approximate block memory.
package amem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND,
        WRITE
    } state_t;

    // Geometry of the default build (2048 words, 8-word blocks).
    localparam int DEF_DEPTH       = 2048;
    localparam int DEF_BLOCK_WORDS = 8;
    localparam int ADDR_W          = $clog2(DEF_DEPTH);
    localparam int CNT_W           = $clog2(DEF_BLOCK_WORDS) + 1;
    localparam int IDX_W           = $clog2(DEF_BLOCK_WORDS);

    // Widest word the distance helper accepts; callers zero-extend into it.
    localparam int DIFF_IN_W = 64;
    localparam int DIFF_W    = DIFF_IN_W + 1;

    // |a-b| computed one bit wider than the operands so it can never wrap.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_IN_W-1:0] a,
                                                   input logic [DIFF_IN_W-1:0] b);
        logic [DIFF_W-1:0] ax;
        logic [DIFF_W-1:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        return (ax >= bx) ? (ax - bx) : (bx - ax);
    endfunction

endpackage

// File: rtl/amem_run_scanner.sv
// Run tracker for one refill block: holds the run's base word, the start
// index of the run and its length, and decides whether the next word extends it.
module amem_run_scanner
    import amem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 8,
    parameter int MAX_ERROR   = 16
) (
    input  logic                           clk,
    input  logic                           start,
    input  logic                           start_exact,
    input  logic [DATA_W-1:0]              start_base,
    input  logic                           extend,
    input  logic                           advance,
    input  logic [DATA_W-1:0]              word,
    output logic [$clog2(BLOCK_WORDS)-1:0] probe_idx,
    output logic [DATA_W-1:0]              base,
    output logic [$clog2(BLOCK_WORDS):0]   cnt,
    output logic                           match,
    output logic                           last
);

    localparam int RUN_CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam logic [RUN_CNT_W-1:0] BLOCK_END = RUN_CNT_W'(BLOCK_WORDS);

    logic [RUN_CNT_W-1:0] idx_q;
    logic [RUN_CNT_W-1:0] cnt_q;
    logic [RUN_CNT_W-1:0] probe_off;
    logic [DATA_W-1:0]    base_q;
    logic                 exact_q;
    logic [DIFF_W-1:0]    diff;
    logic [DIFF_W-1:0]    tol;

    // Offset of the word under test and its distance from the run's base.
    always_comb begin
        probe_off = idx_q + cnt_q;
        diff      = abs_diff(DIFF_IN_W'(word), DIFF_IN_W'(base_q));
        tol       = exact_q ? '0 : DIFF_W'(MAX_ERROR);
    end

    // Low bits select the word inside the block; an offset equal to
    // BLOCK_WORDS aliases word 0 but is never used because match is gated.
    assign probe_idx = probe_off[RUN_CNT_W-2:0];
    assign match     = (probe_off < BLOCK_END) && (diff <= tol);
    assign last      = (probe_off == BLOCK_END);
    assign base      = base_q;
    assign cnt       = cnt_q;

    // Run state: new block, grow the run, or begin the next run at the word that broke it.
    always_ff @(posedge clk) begin
        if (start) begin
            base_q  <= start_base;
            idx_q   <= '0;
            cnt_q   <= RUN_CNT_W'(1);
            exact_q <= start_exact;
        end else if (extend) begin
            cnt_q <= cnt_q + RUN_CNT_W'(1);
        end else if (advance) begin
            idx_q  <= probe_off;
            base_q <= word;
            cnt_q  <= RUN_CNT_W'(1);
        end
    end

endmodule

// File: rtl/approx_block_memory.sv
// Main-memory model that answers block refills with base+run-length tokens
// (approximate or exact) and commits single-word stores. Assumes DEPTH > BLOCK_WORDS.
module approx_block_memory
    import amem_pkg::*;
#(
    parameter int    DATA_W      = 32,
    parameter int    DEPTH       = 2048,
    parameter int    BLOCK_WORDS = 8,
    parameter int    MAX_ERROR   = 16,
    parameter string INIT_FILE   = "memory_data.mem"
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic                         REQ_STORE,
    input  logic                         REQ_EXACT,
    input  logic [$clog2(DEPTH)-1:0]     REQ_ADDR,
    input  logic [DATA_W-1:0]            REQ_WDATA,
    output logic                         RSP_VALID,
    input  logic                         RSP_READY,
    output logic [DATA_W-1:0]            RSP_BASE,
    output logic [$clog2(BLOCK_WORDS):0] RSP_COUNT,
    output logic                         RSP_LAST,
    output logic                         WR_DONE
);

    localparam int MEM_ADDR_W = $clog2(DEPTH);
    localparam int RUN_IDX_W  = $clog2(BLOCK_WORDS);
    localparam int BLK_W      = MEM_ADDR_W - RUN_IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t state;
    state_t next_state;

    logic accept;
    logic start;
    logic extend;
    logic advance;
    logic write_en;
    logic send_set;
    logic send_clr;

    logic [BLK_W-1:0]      blk_q;
    logic [MEM_ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0]     wr_data_q;

    logic [RUN_IDX_W-1:0]  probe_idx;
    logic [DATA_W-1:0]     probe_word;
    logic [DATA_W-1:0]     start_word;
    logic [DATA_W-1:0]     scan_base;
    logic [RUN_IDX_W:0]    scan_cnt;
    logic                  scan_match;
    logic                  scan_last;

    assign accept     = REQ_VALID & REQ_READY;
    assign start_word = mem[{REQ_ADDR[MEM_ADDR_W-1:RUN_IDX_W], {RUN_IDX_W{1'b0}}}];
    assign probe_word = mem[{blk_q, probe_idx}];

    amem_run_scanner #(
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BLOCK_WORDS),
        .MAX_ERROR   (MAX_ERROR)
    ) u_scanner (
        .clk         (CLK),
        .start       (start),
        .start_exact (REQ_EXACT),
        .start_base  (start_word),
        .extend      (extend),
        .advance     (advance),
        .word        (probe_word),
        .probe_idx   (probe_idx),
        .base        (scan_base),
        .cnt         (scan_cnt),
        .match       (scan_match),
        .last        (scan_last)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // FSM next state and per-cycle strobes for the scanner, storage and outputs.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        extend     = 1'b0;
        advance    = 1'b0;
        write_en   = 1'b0;
        send_set   = 1'b0;
        send_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (REQ_STORE) begin
                        next_state = WRITE;
                    end else begin
                        start      = 1'b1;
                        next_state = SCAN;
                    end
                end
            end
            SCAN: begin
                if (scan_match) begin
                    extend = 1'b1;
                end else begin
                    send_set   = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (RSP_READY) begin
                    send_clr = 1'b1;
                    if (RSP_LAST) begin
                        next_state = IDLE;
                    end else begin
                        advance    = 1'b1;
                        next_state = SCAN;
                    end
                end
            end
            WRITE: begin
                write_en   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture block and store operands when a request is accepted.
    always_ff @(posedge CLK) begin
        if (accept) begin
            blk_q     <= REQ_ADDR[MEM_ADDR_W-1:RUN_IDX_W];
            wr_addr_q <= REQ_ADDR;
            wr_data_q <= REQ_WDATA;
        end
    end

    // Storage write port; a store caught by reset is abandoned with the rest of the FSM.
    always_ff @(posedge CLK) begin
        if (write_en && !RST) mem[wr_addr_q] <= wr_data_q;
    end

    // Registered handshake and token outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_BASE  <= '0;
            RSP_COUNT <= '0;
            RSP_LAST  <= 1'b0;
            WR_DONE   <= 1'b0;
        end else begin
            REQ_READY <= (next_state == IDLE);
            WR_DONE   <= write_en;
            if (send_set) begin
                RSP_VALID <= 1'b1;
                RSP_BASE  <= scan_base;
                RSP_COUNT <= scan_cnt;
                RSP_LAST  <= scan_last;
            end else if (send_clr) begin
                RSP_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_approx_block_memory.sv
// Directed bench for approx_block_memory: approximate and exact refills,
// back-pressure, store-then-load, reset during a scan and the no-wrap distance.
module tb_approx_block_memory;
    import amem_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic              req_exact;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_base;
    logic [CNT_W-1:0]  rsp_count;
    logic              rsp_last;
    logic              wr_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]      tok_base [16];
    logic [CNT_W-1:0] tok_cnt  [16];
    logic             tok_last [16];
    int               ntok;
    int               first_lat;

    always #5 clk = ~clk;

    approx_block_memory #(
        .DATA_W      (32),
        .DEPTH       (2048),
        .BLOCK_WORDS (8),
        .MAX_ERROR   (16),
        .INIT_FILE   ("")
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_STORE (req_store),
        .REQ_EXACT (req_exact),
        .REQ_ADDR  (req_addr),
        .REQ_WDATA (req_wdata),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_BASE  (rsp_base),
        .RSP_COUNT (rsp_count),
        .RSP_LAST  (rsp_last),
        .WR_DONE   (wr_done)
    );

    // Present a request at a falling edge and hold it until accepted; returns
    // at the falling edge right after the accepting rising edge.
    task automatic issue(input logic st, input logic ex, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d);
        int waitc;
        req_valid = 1'b1;
        req_store = st;
        req_exact = ex;
        req_addr  = a;
        req_wdata = d;
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_accept: req_ready=%0b after %0d cycles, required 1", req_ready, waitc);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic store_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        issue(1'b0 | 1'b1, 1'b0, a, d);
        @(negedge clk);
    endtask

    // Drain one refill. The first token is refused for 'stall' cycles while it
    // is checked against (sb,sc,sl). first_lat counts falling edges from accept.
    task automatic collect(input int stall, input logic [31:0] sb, input int sc, input logic sl);
        int j;
        int stall_left;
        bit fin;
        for (int i = 0; i < 16; i++) begin
            tok_base[i] = 'x;
            tok_cnt[i]  = 'x;
            tok_last[i] = 1'bx;
        end
        ntok = 0;
        first_lat = -1;
        fin = 1'b0;
        j = 0;
        stall_left = stall;
        while (!fin && j < 200) begin
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (first_lat < 0) first_lat = j;
                if (ntok == 0 && stall_left > 0) begin
                    n_tests++;
                    if (rsp_base !== sb || rsp_count !== CNT_W'(sc) || rsp_last !== sl) begin
                        n_fail++;
                        $display("FAIL stall_hold: got (%0h,%0d,%0b) required (%0h,%0d,%0b)",
                                 rsp_base, rsp_count, rsp_last, sb, sc, sl);
                    end
                    stall_left--;
                end else begin
                    rsp_ready = 1'b1;
                    if (ntok < 16) begin
                        tok_base[ntok] = rsp_base;
                        tok_cnt[ntok]  = rsp_count;
                        tok_last[ntok] = rsp_last;
                    end
                    ntok++;
                    if (rsp_last) fin = 1'b1;
                end
            end
            @(posedge clk);
            @(negedge clk);
            j++;
        end
        rsp_ready = 1'b0;
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL collect_timeout: %0d tokens and no LAST, required a LAST token", ntok);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_exact = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, rsp_base, rsp_count, rsp_last, wr_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b base=%0h count=%0d last=%0b wr_done=%0b required all 0",
                     req_ready, rsp_valid, rsp_base, rsp_count, rsp_last, wr_done);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_exit_ready: got %0b required 1", req_ready);
        end
    endtask

    task automatic preload();
        logic [31:0] blk0 [8];
        blk0 = '{32'd100, 32'd105, 32'd110, 32'd90, 32'd300, 32'd301, 32'd302, 32'd303};
        for (int i = 0; i < 8; i++) store_word(ADDR_W'(i), blk0[i]);
        for (int i = 0; i < 8; i++) store_word(ADDR_W'(16 + i), 32'd1000);
        store_word(ADDR_W'(24), 32'h0);
        for (int i = 1; i < 8; i++) store_word(ADDR_W'(24 + i), 32'hFFFF_FFFF);
    endtask

    task automatic test_approx_load();
        issue(1'b0, 1'b0, ADDR_W'(5), 32'h0);
        collect(0, 32'h0, 0, 1'b0);
        n_tests++;
        if (ntok !== 2) begin
            n_fail++;
            $display("FAIL approx_ntok: got %0d required 2", ntok);
        end
        // First token registered on edge accept+4 (cnt=4), seen at the edge after it.
        n_tests++;
        if (first_lat !== 4) begin
            n_fail++;
            $display("FAIL approx_latency: got %0d required 4", first_lat);
        end
        n_tests++;
        if (tok_base[0] !== 32'd100 || tok_cnt[0] !== 4'd4 || tok_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL approx_tok0: got (%0d,%0d,%0b) required (100,4,0)", tok_base[0], tok_cnt[0], tok_last[0]);
        end
        n_tests++;
        if (tok_base[1] !== 32'd300 || tok_cnt[1] !== 4'd4 || tok_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL approx_tok1: got (%0d,%0d,%0b) required (300,4,1)", tok_base[1], tok_cnt[1], tok_last[1]);
        end
    endtask

    task automatic test_exact_load();
        logic [31:0] eb [8];
        eb = '{32'd100, 32'd105, 32'd110, 32'd90, 32'd300, 32'd301, 32'd302, 32'd303};
        issue(1'b0, 1'b1, ADDR_W'(2), 32'h0);
        collect(0, 32'h0, 0, 1'b0);
        n_tests++;
        if (ntok !== 8) begin
            n_fail++;
            $display("FAIL exact_ntok: got %0d required 8", ntok);
        end
        n_tests++;
        if (first_lat !== 1) begin
            n_fail++;
            $display("FAIL exact_latency: got %0d required 1", first_lat);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (tok_base[i] !== eb[i] || tok_cnt[i] !== 4'd1 || tok_last[i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL exact_tok%0d: got (%0d,%0d,%0b) required (%0d,1,%0b)",
                         i, tok_base[i], tok_cnt[i], tok_last[i], eb[i], (i == 7));
            end
        end
    endtask

    task automatic test_back_pressure();
        int extra;
        issue(1'b0, 1'b0, ADDR_W'(0), 32'h0);
        // A store presented while the load is busy must be ignored.
        req_valid = 1'b1;
        req_store = 1'b1;
        req_addr  = ADDR_W'(1);
        req_wdata = 32'd55;
        collect(5, 32'd100, 4, 1'b0);
        req_valid = 1'b0;
        req_store = 1'b0;
        n_tests++;
        if (ntok !== 2 || first_lat !== 4) begin
            n_fail++;
            $display("FAIL bp_ntok_latency: got ntok=%0d lat=%0d required ntok=2 lat=4", ntok, first_lat);
        end
        n_tests++;
        if (tok_base[0] !== 32'd100 || tok_cnt[0] !== 4'd4 || tok_base[1] !== 32'd300 || tok_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_tokens: got (%0d,%0d) (%0d,last=%0b) required (100,4) (300,last=1)",
                     tok_base[0], tok_cnt[0], tok_base[1], tok_last[1]);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        n_tests++;
        if (extra !== 0 || wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_quiet: got %0d extra valid cycles wr_done=%0b required 0 and 0", extra, wr_done);
        end
    endtask

    task automatic test_store_then_load();
        issue(1'b1, 1'b0, ADDR_W'(17), 32'h0000_DEAD);
        n_tests++;
        if (wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_early: got %0b required 0", wr_done);
        end
        @(negedge clk);
        n_tests++;
        if (wr_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_done_pulse: got %0b required 1", wr_done);
        end
        @(negedge clk);
        n_tests++;
        if (wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_width: got %0b required 0", wr_done);
        end
        issue(1'b0, 1'b0, ADDR_W'(16), 32'h0);
        collect(0, 32'h0, 0, 1'b0);
        n_tests++;
        if (ntok !== 3) begin
            n_fail++;
            $display("FAIL store_ntok: got %0d required 3", ntok);
        end
        n_tests++;
        if (tok_base[0] !== 32'd1000 || tok_cnt[0] !== 4'd1 || tok_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL store_tok0: got (%0h,%0d,%0b) required (3e8,1,0)", tok_base[0], tok_cnt[0], tok_last[0]);
        end
        n_tests++;
        if (tok_base[1] !== 32'h0000_DEAD || tok_cnt[1] !== 4'd1 || tok_last[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL store_tok1: got (%0h,%0d,%0b) required (dead,1,0)", tok_base[1], tok_cnt[1], tok_last[1]);
        end
        n_tests++;
        if (tok_base[2] !== 32'd1000 || tok_cnt[2] !== 4'd6 || tok_last[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL store_tok2: got (%0h,%0d,%0b) required (3e8,6,1)", tok_base[2], tok_cnt[2], tok_last[2]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        issue(1'b0, 1'b0, ADDR_W'(3), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, rsp_base, rsp_count, rsp_last, wr_done} !== '0) begin
            n_fail++;
            $display("FAIL midscan_reset: ready=%0b valid=%0b base=%0h count=%0d last=%0b wr_done=%0b required all 0",
                     req_ready, rsp_valid, rsp_base, rsp_count, rsp_last, wr_done);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_ready: got %0b required 1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midscan_dropped: got %0d valid cycles required 0", seen);
        end
        issue(1'b0, 1'b0, ADDR_W'(0), 32'h0);
        collect(0, 32'h0, 0, 1'b0);
        n_tests++;
        if (ntok !== 2 || tok_base[0] !== 32'd100 || tok_cnt[0] !== 4'd4 ||
            tok_base[1] !== 32'd300 || tok_cnt[1] !== 4'd4 || tok_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_memory: got %0d tokens (%0d,%0d) (%0d,%0d,%0b) required 2 tokens (100,4) (300,4,1)",
                     ntok, tok_base[0], tok_cnt[0], tok_base[1], tok_cnt[1], tok_last[1]);
        end
    endtask

    task automatic test_no_wrap();
        issue(1'b0, 1'b0, ADDR_W'(29), 32'h0);
        collect(0, 32'h0, 0, 1'b0);
        n_tests++;
        if (ntok !== 2 || first_lat !== 1) begin
            n_fail++;
            $display("FAIL wrap_ntok_latency: got ntok=%0d lat=%0d required ntok=2 lat=1", ntok, first_lat);
        end
        n_tests++;
        if (tok_base[0] !== 32'h0 || tok_cnt[0] !== 4'd1 || tok_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_tok0: got (%0h,%0d,%0b) required (0,1,0)", tok_base[0], tok_cnt[0], tok_last[0]);
        end
        n_tests++;
        if (tok_base[1] !== 32'hFFFF_FFFF || tok_cnt[1] !== 4'd7 || tok_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_tok1: got (%0h,%0d,%0b) required (ffffffff,7,1)", tok_base[1], tok_cnt[1], tok_last[1]);
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_approx_load();
        test_exact_load();
        test_back_pressure();
        test_store_then_load();
        test_reset_mid_scan();
        test_no_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
